dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter TIMEOUT, default 15, SHALL set the maximum number of REQ-state cycles waited for ramstate==ACCESS before an error.
REQ-002 CLK  input  1  SHALL be the single clock; all state updates on posedge CLK.
REQ-003 nRST  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 dmemREN  input  1  SHALL be the datapath read request, held until dhit.
REQ-005 dmemWEN  input  1  SHALL be the datapath write request, held until dhit.
REQ-006 dmemaddr  input  32  SHALL be the request word address.
REQ-007 dmemstore  input  32  SHALL be the write data.
REQ-008 dhit  output  1  SHALL be a one-cycle completion strobe.
REQ-009 dmemload  output  32  SHALL be the read data, valid while dhit=1.
REQ-010 derror  output  1  SHALL be a one-cycle error strobe, coincident with dhit.
REQ-011 ramREN, ramWEN  output  1 each  SHALL be the RAM read/write strobes.
REQ-012 ramaddr, ramstore  output  32 each  SHALL be the RAM address and write data.
REQ-013 ramload  input  32  SHALL be the RAM read data.
REQ-014 ramstate  input  2  SHALL be RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Function
REQ-015 FSM states SHALL be IDLE, REQ, DONE, ERR, all registered.
REQ-016 IDLE: on dmemWEN or dmemREN, latch dmemaddr, dmemstore and op type, go REQ; dmemWEN wins if both are high.
REQ-017 REQ: ramREN/ramWEN per latched op, ramaddr/ramstore from latched values; these outputs SHALL be 0 in every other state.
REQ-018 REQ with ramstate==ACCESS: register ramload into dmemload (reads only), go DONE.
REQ-019 REQ with ramstate==ERROR, or when the cycle counter reaches TIMEOUT without ACCESS: go ERR.
REQ-020 The cycle counter SHALL clear on entry to REQ, increment each REQ cycle, and saturate (no wrap).
REQ-021 REQ with both dmemREN and dmemWEN low (request withdrawn): abort to IDLE, no dhit, RAM strobes low on the next cycle.
REQ-022 DONE: dhit=1 for one cycle, then IDLE; on writes dmemload SHALL hold its previous value.
REQ-023 ERR: dhit=1, derror=1 and dmemload=32'hBAD1BAD1 for one cycle, then IDLE.
REQ-024 A request still asserted in the IDLE cycle after dhit SHALL start a new transaction (minimum 1 idle cycle between transactions).
REQ-025 Minimum latency without buffer SHALL be: request at cycle 0, REQ at 1, ACCESS at 1, dhit at 2.

Reset
REQ-026 nRST low SHALL force, immediately: state IDLE, dhit=0, derror=0, dmemload=0, all ram* outputs 0, counter 0, and buffer invalid.
REQ-027 Reset asserted mid-REQ SHALL drop RAM strobes asynchronously and produce no dhit.

Configuration
REQ-028 Macro DLOAD_BUF_EN SHALL enable a one-entry read buffer holding valid, address and data.
REQ-029 With DLOAD_BUF_EN: each read completion in DONE loads the buffer; an IDLE read whose address matches a valid entry goes directly to DONE with the buffered data (dhit next cycle, no RAM access).
REQ-030 With DLOAD_BUF_EN: a completed write to the buffered address updates the buffered data; ERR or reset invalidates the buffer.
REQ-031 Without DLOAD_BUF_EN: no buffer logic; every read SHALL access RAM.

Verification
REQ-032 Read 0x40, ramstate ACCESS immediately, ramload=0xCAFEF00D -> dhit at cycle 2, dmemload=0xCAFEF00D, ramREN high exactly cycle 1.
REQ-033 Write 0x80/0x12345678, ramstate BUSY 3 cycles then ACCESS -> ramWEN high 4 cycles, ramstore=0x12345678, a single dhit, dmemload unchanged.
REQ-034 Read with ramstate stuck BUSY, TIMEOUT=15 -> ERR after 15 REQ cycles; dhit=derror=1, dmemload=0xBAD1BAD1.
REQ-035 Read started, request dropped in the 2nd REQ cycle -> IDLE, no dhit, ramREN low next cycle; nRST pulsed mid-REQ -> all outputs 0 immediately.
REQ-036 DLOAD_BUF_EN: read 0x40 (RAM), read 0x40 again -> dhit 1 cycle after request, ramREN never asserted; write 0x40=0x1 then read 0x40 -> dmemload=0x1 from the buffer.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
//   Bridges a held datapath load/store request (dmemREN/dmemWEN) onto a
//   simple RAM strobe interface and returns a one-cycle completion strobe.
//   A RAM ERROR status, or TIMEOUT REQ cycles without ACCESS, completes the
//   transaction with derror=1 and dmemload=32'hBAD1BAD1 for that cycle.
//   The datapath may withdraw its request while waiting, which aborts the
//   transaction silently.
//
// Configuration macro:
//   DLOAD_BUF_EN - adds a one-entry read buffer (valid/address/data). Reads
//                  that hit it complete one cycle after the request with no
//                  RAM access.
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   dmemREN, dmemWEN     datapath read/write request, held until dhit
//   dmemaddr, dmemstore  request address and write data
//   dhit, derror         completion / error strobes (one cycle)
//   dmemload             read data, valid while dhit=1
//   ramREN, ramWEN       RAM read/write strobes
//   ramaddr, ramstore    RAM address / write data
//   ramload, ramstate    RAM read data / status (FREE, BUSY, ACCESS, ERROR)
module dmem_responder #(
  parameter int TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        derror,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  localparam int          CW         = $clog2(TIMEOUT + 2);
  localparam logic [CW:0] TMO        = (CW + 1)'(TIMEOUT);
  localparam logic [1:0]  RAM_ACCESS = 2'd2;
  localparam logic [1:0]  RAM_ERROR  = 2'd3;
  localparam logic [31:0] ERR_WORD   = 32'hBAD1_BAD1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic          is_write_r, is_write_s;
  logic [31:0]   addr_r, addr_s;
  logic [31:0]   store_r, store_s;
  logic [31:0]   data_r, data_s;          // last successfully read word
  logic [CW-1:0] count_r, count_s;
  logic [CW:0]   count_inc_s;
  logic          dhit_r, dhit_s;
  logic          derror_r, derror_s;
  logic [31:0]   load_r, load_s;
  logic          ren_r, ren_s;
  logic          wen_r, wen_s;
  logic [31:0]   raddr_r, raddr_s;
  logic [31:0]   rstore_r, rstore_s;
  logic          buf_hit_s;

`ifdef DLOAD_BUF_EN
  logic          rbuf_valid_r, rbuf_valid_s;
  logic [31:0]   rbuf_addr_r, rbuf_addr_s;
  logic [31:0]   rbuf_data_r, rbuf_data_s;

  // A pure read (write wins if both are high) that matches the buffer skips RAM.
  assign buf_hit_s = dmemREN && !dmemWEN && rbuf_valid_r && (rbuf_addr_r == dmemaddr);
`else
  assign buf_hit_s = 1'b0;
`endif

  // Next state, latched request fields and next values of every output register.
  always_comb begin
    state_s     = state_r;
    is_write_s  = is_write_r;
    addr_s      = addr_r;
    store_s     = store_r;
    data_s      = data_r;
    count_s     = count_r;
    count_inc_s = {1'b0, count_r} + {{CW{1'b0}}, 1'b1};
    ren_s       = 1'b0;
    wen_s       = 1'b0;
    raddr_s     = 32'd0;
    rstore_s    = 32'd0;
    case (state_r)
      IDLE: begin
        if (dmemWEN || dmemREN) begin
          is_write_s = dmemWEN;
          addr_s     = dmemaddr;
          store_s    = dmemstore;
          count_s    = {CW{1'b0}};
          if (buf_hit_s) begin
`ifdef DLOAD_BUF_EN
            data_s  = rbuf_data_r;
`endif
            state_s = DONE;
          end else begin
            state_s  = REQ;
            ren_s    = !dmemWEN;
            wen_s    = dmemWEN;
            raddr_s  = dmemaddr;
            rstore_s = dmemstore;
          end
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        // Saturate rather than wrap so a stuck RAM can never alias to a fresh count.
        count_s = count_inc_s[CW] ? count_r : count_inc_s[CW-1:0];
        if (!dmemREN && !dmemWEN) begin
          state_s = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          state_s = DONE;
          if (!is_write_r) begin
            data_s = ramload;
          end else begin
            data_s = data_r;
          end
        end else if ((ramstate == RAM_ERROR) || (count_inc_s >= TMO)) begin
          state_s = ERR;
        end else begin
          state_s  = REQ;
          ren_s    = !is_write_r;
          wen_s    = is_write_r;
          raddr_s  = addr_r;
          rstore_s = store_r;
        end
      end
      DONE:    state_s = IDLE;
      ERR:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
    dhit_s   = (state_s == DONE) || (state_s == ERR);
    derror_s = (state_s == ERR);
    // The error word is shown for the ERR cycle only; afterwards the last read returns.
    load_s   = (state_s == ERR) ? ERR_WORD : data_s;
  end

  // State, request latches and registered outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r    <= IDLE;
      is_write_r <= 1'b0;
      addr_r     <= 32'd0;
      store_r    <= 32'd0;
      data_r     <= 32'd0;
      count_r    <= {CW{1'b0}};
      dhit_r     <= 1'b0;
      derror_r   <= 1'b0;
      load_r     <= 32'd0;
      ren_r      <= 1'b0;
      wen_r      <= 1'b0;
      raddr_r    <= 32'd0;
      rstore_r   <= 32'd0;
    end else begin
      state_r    <= state_s;
      is_write_r <= is_write_s;
      addr_r     <= addr_s;
      store_r    <= store_s;
      data_r     <= data_s;
      count_r    <= count_s;
      dhit_r     <= dhit_s;
      derror_r   <= derror_s;
      load_r     <= load_s;
      ren_r      <= ren_s;
      wen_r      <= wen_s;
      raddr_r    <= raddr_s;
      rstore_r   <= rstore_s;
    end
  end

`ifdef DLOAD_BUF_EN
  // Buffer update: fill on RAM read completion, track writes to the held address, drop on error.
  always_comb begin
    rbuf_valid_s = rbuf_valid_r;
    rbuf_addr_s  = rbuf_addr_r;
    rbuf_data_s  = rbuf_data_r;
    if ((state_r == REQ) && (state_s == DONE)) begin
      if (!is_write_r) begin
        rbuf_valid_s = 1'b1;
        rbuf_addr_s  = addr_r;
        rbuf_data_s  = ramload;
      end else if (rbuf_valid_r && (rbuf_addr_r == addr_r)) begin
        rbuf_data_s  = store_r;
      end else begin
        rbuf_data_s  = rbuf_data_r;
      end
    end else if (state_s == ERR) begin
      rbuf_valid_s = 1'b0;
    end else begin
      rbuf_valid_s = rbuf_valid_r;
    end
  end

  // Read buffer registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rbuf_valid_r <= 1'b0;
      rbuf_addr_r  <= 32'd0;
      rbuf_data_r  <= 32'd0;
    end else begin
      rbuf_valid_r <= rbuf_valid_s;
      rbuf_addr_r  <= rbuf_addr_s;
      rbuf_data_r  <= rbuf_data_s;
    end
  end
`endif

  assign dhit     = dhit_r;
  assign derror   = derror_r;
  assign dmemload = load_r;
  assign ramREN   = ren_r;
  assign ramWEN   = wen_r;
  assign ramaddr  = raddr_r;
  assign ramstore = rstore_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios followed by
// random transactions against a transaction-level model (word memory, last
// read value, optional one-entry read buffer).
module tb_dmem_responder;

  localparam int TMO = 15;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore;
  logic        dhit, derror;
  logic [31:0] dmemload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  always #5 CLK = ~CLK;

  dmem_responder #(.TIMEOUT(TMO)) dut (
    .CLK(CLK), .nRST(nRST),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload), .derror(derror),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  int checks = 0;
  int failures = 0;

  // Model state
  logic [31:0] mem [logic [31:0]];
  logic [31:0] last_data;
  bit          bvalid;
  logic [31:0] baddr, bdata;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // One complete transaction: bench plays the RAM, model predicts the outcome.
  task automatic run_txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input int wait_n, input bit force_err, input string tag);
    int          strobes = 0;
    int          lat = 0;
    bit          got = 0;
    bit          bad_bus = 0;
    bit          hit = 0;
    int          exp_strobes, exp_lat;
    bit          exp_err;
    logic [31:0] exp_load;
    logic [31:0] obs_load = 32'd0;
    logic        obs_err = 1'b0;
`ifdef DLOAD_BUF_EN
    hit = !we && bvalid && (baddr == a);
`endif
    if (hit) begin
      exp_strobes = 0; exp_lat = 1; exp_err = 0; exp_load = bdata;
    end else if (!force_err && (wait_n + 1 <= TMO)) begin
      exp_strobes = wait_n + 1; exp_lat = wait_n + 2; exp_err = 0;
      exp_load = we ? last_data : mem_rd(a);
    end else begin
      exp_strobes = (wait_n + 1 < TMO) ? wait_n + 1 : TMO;
      exp_lat = exp_strobes + 1; exp_err = 1; exp_load = 32'hBAD1_BAD1;
    end

    dmemWEN = we; dmemREN = !we; dmemaddr = a; dmemstore = d;
    for (int c = 1; c <= 40 && !got; c++) begin
      tick;
      if (dhit) begin
        got = 1; lat = c; obs_load = dmemload; obs_err = derror;
        dmemREN = 1'b0; dmemWEN = 1'b0; ramstate = 2'd0;
      end else if (ramREN || ramWEN) begin
        strobes++;
        if (ramaddr !== a || ramWEN !== we || ramREN !== !we || (we && ramstore !== d)) bad_bus = 1;
        ramstate = (strobes > wait_n) ? (force_err ? 2'd3 : 2'd2) : 2'd1;
        ramload  = mem_rd(ramaddr);
      end else begin
        ramstate = 2'd0;
      end
    end
    dmemREN = 1'b0; dmemWEN = 1'b0;

    check({tag, "_dhit"},    32'(got), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_strobes"}, 32'(strobes), 32'(exp_strobes));
    check({tag, "_dmemload"}, obs_load, exp_load);
    check({tag, "_derror"},  32'(obs_err), 32'(exp_err));
    check({tag, "_rambus"},  32'(bad_bus), 32'd0);

    if (!exp_err) begin
      if (we) begin
        mem[a] = d;
        if (bvalid && baddr == a) bdata = d;
      end else begin
        last_data = exp_load;
        bvalid = 1; baddr = a; bdata = exp_load;
      end
    end else begin
      bvalid = 0;
    end
`ifndef DLOAD_BUF_EN
    bvalid = 0;
`endif

    // Strobes last exactly one cycle and the error word does not linger.
    tick;
    check({tag, "_dhit_once"},  32'(dhit), 32'd0);
    check({tag, "_derror_off"}, 32'(derror), 32'd0);
    check({tag, "_load_after"}, dmemload, last_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = 32'd0; dmemstore = 32'd0;
    ramload = 32'd0; ramstate = 2'd0;
    last_data = 32'd0; bvalid = 0; baddr = 32'd0; bdata = 32'd0;
    mem[32'h40] = 32'hCAFE_F00D;
    #22;
    check("reset_dhit", 32'(dhit), 32'd0);
    check("reset_derror", 32'(derror), 32'd0);
    check("reset_dmemload", dmemload, 32'd0);
    check("reset_ramstrobes", 32'({ramREN, ramWEN}), 32'd0);
    check("reset_ramaddr", ramaddr, 32'd0);
    nRST = 1'b1;
    tick;

    // Minimum-latency read, write with BUSY wait, stuck-BUSY timeout, RAM error.
    run_txn(1'b0, 32'h40, 32'h0, 0, 0, "rd40");
    run_txn(1'b1, 32'h80, 32'h1234_5678, 3, 0, "wr80");
    run_txn(1'b0, 32'h100, 32'h0, 100, 0, "timeout");
    run_txn(1'b0, 32'h104, 32'h0, 2, 1, "ramerr");
    run_txn(1'b0, 32'h80, 32'h0, 14, 0, "rd80_late");

    // Request withdrawn in the second REQ cycle.
    dmemREN = 1'b1; dmemaddr = 32'h48; ramstate = 2'd1;
    tick;
    check("abort_ren_c1", 32'(ramREN), 32'd1);
    tick;
    check("abort_ren_c2", 32'(ramREN), 32'd1);
    dmemREN = 1'b0;
    tick;
    check("abort_ren_off", 32'(ramREN), 32'd0);
    check("abort_no_dhit", 32'(dhit), 32'd0);
    tick;
    check("abort_no_dhit2", 32'(dhit), 32'd0);
    ramstate = 2'd0;

    // Reset pulsed mid-REQ clears everything without waiting for a clock.
    dmemREN = 1'b1; dmemaddr = 32'h4C; ramstate = 2'd1;
    tick;
    check("rstreq_ren", 32'(ramREN), 32'd1);
    #2 nRST = 1'b0;
    #1;
    check("rstreq_ren_off", 32'(ramREN), 32'd0);
    check("rstreq_ramaddr", ramaddr, 32'd0);
    check("rstreq_dhit", 32'(dhit), 32'd0);
    check("rstreq_dmemload", dmemload, 32'd0);
    dmemREN = 1'b0; ramstate = 2'd0;
    last_data = 32'd0; bvalid = 0;
    tick;
    #2 nRST = 1'b1;
    tick;

    // Read-buffer scenario (plain RAM accesses when the buffer is absent).
    run_txn(1'b0, 32'h40, 32'h0, 0, 0, "buf_rd1");
    run_txn(1'b0, 32'h40, 32'h0, 1, 0, "buf_rd2");
    run_txn(1'b1, 32'h40, 32'h1, 0, 0, "buf_wr");
    run_txn(1'b0, 32'h40, 32'h0, 2, 0, "buf_rd3");

    // Random traffic over a few addresses so buffer hits and evictions occur.
    for (int i = 0; i < 40; i++) begin
      int          r;
      int          wn;
      logic        we;
      logic [31:0] a;
      r  = int'($urandom_range(0, 15));
      we = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 3)) << 6;
      wn = (r == 1) ? 20 : int'($urandom_range(0, 3));
      run_txn(we, a, $urandom, wn, (r == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
